// File: rtl/jht_nway.sv
// jht_nway: N-way set-associative jump history table with 2-bit confidence and tree-PLRU replacement.
module jht_nway #(
  parameter int ASSOCIATIVITY = 4,
  parameter int SET_NUM = 16,
  parameter int TAG_BITS = 18,
  parameter int INDEX_SHIFT = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] j_pc,
  output logic [31:0] predict_pc,
  output logic        hit,
  output logic        hit_pc,
  output logic        hit_pcp4,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_dest,
  input  logic        upd_taken,
  input  logic        flush
);
  localparam int WB = $clog2(ASSOCIATIVITY);
  localparam int IB = $clog2(SET_NUM);
  localparam int PB = ASSOCIATIVITY - 1;

  logic [TAG_BITS-1:0] r_tag [SET_NUM][ASSOCIATIVITY];
  logic [31:0] r_dest [SET_NUM][ASSOCIATIVITY];
  logic [SET_NUM-1:0][ASSOCIATIVITY-1:0] r_valid;
  logic [SET_NUM-1:0][ASSOCIATIVITY-1:0][1:0] r_conf;
  logic [SET_NUM-1:0][PB-1:0] r_plru;
  logic r_uv, r_utaken;
  logic [31:0] r_upc, r_udest;

  logic [31:0] w_pcp4;
  logic [IB-1:0] w_idx_p, w_idx_u;
  logic [TAG_BITS-1:0] w_tag_pc, w_tag_p4, w_tag_u;
  logic [WB-1:0] w_way_pc, w_way_p4, w_way, w_uway, w_inv_way, w_wr_way;
  logic w_uhit, w_inv, w_u2, w_unused;
  logic [PB-1:0] w_plru_p, w_plru_ub;
  logic [1:0] w_conf_old, w_conf_new;

  // Heap-ordered tree: node n has children 2n+1 / 2n+2; a 0 bit points the victim at the lower half.
  function automatic logic [PB-1:0] plru_touch(input logic [PB-1:0] b, input logic [WB-1:0] w);
    logic [PB-1:0] r;
    r = b;
    for (int l = 0; l < WB; l++)
      for (int k = 0; k < (1 << l); k++)
        if ((int'(w) >> (WB - l)) == k) r[(1 << l) - 1 + k] = ~w[WB - 1 - l];
    return r;
  endfunction

  function automatic logic [WB-1:0] plru_victim(input logic [PB-1:0] b);
    int v;
    logic s;
    v = 0;
    for (int l = 0; l < WB; l++) begin
      s = 1'b0;
      for (int k = 0; k < (1 << l); k++)
        if (v == k) s = b[(1 << l) - 1 + k];
      v = 2 * v + int'(s);
    end
    return v[WB-1:0];
  endfunction

  assign w_pcp4 = j_pc + 32'd4;
  assign w_idx_p = j_pc[INDEX_SHIFT +: IB];
  assign w_tag_pc = j_pc[2 +: TAG_BITS];
  assign w_tag_p4 = w_pcp4[2 +: TAG_BITS];
  assign w_idx_u = r_upc[INDEX_SHIFT +: IB];
  assign w_tag_u = r_upc[2 +: TAG_BITS];
  assign w_unused = ^{j_pc, w_pcp4, r_upc};

  always_comb begin
    hit_pc = 1'b0;
    hit_pcp4 = 1'b0;
    w_way_pc = '0;
    w_way_p4 = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (r_valid[w_idx_p][w] && r_tag[w_idx_p][w] == w_tag_pc) begin
        hit_pc = 1'b1;
        w_way_pc = WB'(w);
      end
      if (r_valid[w_idx_p][w] && r_tag[w_idx_p][w] == w_tag_p4) begin
        hit_pcp4 = 1'b1;
        w_way_p4 = WB'(w);
      end
    end
  end

  assign w_way = hit_pc ? w_way_pc : w_way_p4;
  assign hit = hit_pc | hit_pcp4;
  assign predict_pc = hit ? r_dest[w_idx_p][w_way] : '0;
  assign pred_taken = hit & r_conf[w_idx_p][w_way][1];

  // Descending scan: first tag match is the highest way, last invalid seen is the lowest.
  always_comb begin
    w_uhit = 1'b0;
    w_uway = '0;
    w_inv = 1'b0;
    w_inv_way = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (!r_valid[w_idx_u][w]) begin
        w_inv = 1'b1;
        w_inv_way = WB'(w);
      end else if (!w_uhit && r_tag[w_idx_u][w] == w_tag_u) begin
        w_uhit = 1'b1;
        w_uway = WB'(w);
      end
    end
  end

  // The predict touch is applied first, so an update in the same set works from its result.
  assign w_plru_p = plru_touch(r_plru[w_idx_p], w_way);
  assign w_plru_ub = (hit && w_idx_p == w_idx_u) ? w_plru_p : r_plru[w_idx_u];
  assign w_wr_way = w_uhit ? w_uway : w_inv ? w_inv_way : plru_victim(w_plru_ub);
  assign w_conf_old = r_conf[w_idx_u][w_wr_way];
  assign w_conf_new = !w_uhit ? 2'd2 :
                      r_utaken ? (r_dest[w_idx_u][w_wr_way] != r_udest ? 2'd2 :
                                  w_conf_old == 2'd3 ? 2'd3 : w_conf_old + 2'd1) :
                      (w_conf_old == 2'd0 ? 2'd0 : w_conf_old - 2'd1);
  assign w_u2 = r_uv & (w_uhit | r_utaken);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
      r_conf <= '0;
      r_plru <= '0;
      r_uv <= 1'b0;
      r_upc <= '0;
      r_udest <= '0;
      r_utaken <= 1'b0;
    end else if (flush) begin
      r_valid <= '0;
      r_plru <= '0;
      r_uv <= 1'b0;
    end else begin
      r_uv <= upd_valid;
      r_upc <= upd_pc;
      r_udest <= upd_dest;
      r_utaken <= upd_taken;
      if (hit) r_plru[w_idx_p] <= w_plru_p;
      if (w_u2) begin
        r_valid[w_idx_u][w_wr_way] <= 1'b1;
        r_conf[w_idx_u][w_wr_way] <= w_conf_new;
        r_plru[w_idx_u] <= plru_touch(w_plru_ub, w_wr_way);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_uv && r_utaken && !flush) begin
      r_tag[w_idx_u][w_wr_way] <= w_tag_u;
      r_dest[w_idx_u][w_wr_way] <= r_udest;
    end
  end
endmodule

// File: tb/tb_jht_nway.sv
// tb_jht_nway: randomized and directed checks of jht_nway against a set/way reference model.
module tb_jht_nway;
  localparam logic [31:0] PARK = 32'h8000_0000;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic [31:0] j_pc = '0, upd_pc = '0, upd_dest = '0, predict_pc;
  logic hit, hit_pc, hit_pcp4, pred_taken;
  logic upd_valid = 1'b0, upd_taken = 1'b0, flush = 1'b0;
  int n_tests = 0, n_fail = 0;

  bit m_valid [16][4];
  int m_tag [16][4];
  logic [31:0] m_dest [16][4];
  int m_conf [16][4];
  int m_node [16][3];
  bit pend_v, pend_taken;
  logic [31:0] pend_pc, pend_dest;

  jht_nway dut (
    .clk(clk), .resetn(resetn), .j_pc(j_pc), .predict_pc(predict_pc),
    .hit(hit), .hit_pc(hit_pc), .hit_pcp4(hit_pcp4), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_dest(upd_dest),
    .upd_taken(upd_taken), .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic int f_set(input logic [31:0] a);
    return int'((a >> 7) & 32'hF);
  endfunction

  function automatic int f_tag(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FFFF);
  endfunction

  function automatic int m_find(input int s, input int t);
    int r;
    r = -1;
    for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_tag[s][w] == t) r = w;
    return r;
  endfunction

  function automatic int m_way(input logic [31:0] pc);
    int a;
    a = m_find(f_set(pc), f_tag(pc));
    return (a >= 0) ? a : m_find(f_set(pc), f_tag(pc + 32'd4));
  endfunction

  function automatic logic [35:0] m_out(input logic [31:0] pc);
    int s, a, b, w;
    s = f_set(pc);
    a = m_find(s, f_tag(pc));
    b = m_find(s, f_tag(pc + 32'd4));
    w = (a >= 0) ? a : b;
    if (w < 0) return '0;
    return {1'b1, a >= 0, b >= 0, m_conf[s][w] >= 2, m_dest[s][w]};
  endfunction

  // Tree PLRU as interval halving: each node on the way's path ends up pointing at the other half.
  task automatic m_touch(input int s, input int w);
    int lo, hi, n, mid;
    lo = 0; hi = 4; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin m_node[s][n] = 1; n = 2 * n + 1; hi = mid; end
      else begin m_node[s][n] = 0; n = 2 * n + 2; lo = mid; end
    end
  endtask

  function automatic int m_victim(input int s);
    int lo, hi, n, mid;
    lo = 0; hi = 4; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_node[s][n] == 0) begin n = 2 * n + 1; hi = mid; end
      else begin n = 2 * n + 2; lo = mid; end
    end
    return lo;
  endfunction

  task automatic m_apply(input logic [31:0] pc, input logic [31:0] dest, input bit taken);
    int s, w;
    s = f_set(pc);
    w = m_find(s, f_tag(pc));
    if (w >= 0) begin
      if (taken) begin
        m_conf[s][w] = (m_dest[s][w] != dest) ? 2 : (m_conf[s][w] < 3 ? m_conf[s][w] + 1 : 3);
        m_dest[s][w] = dest;
      end else m_conf[s][w] = (m_conf[s][w] > 0) ? m_conf[s][w] - 1 : 0;
      m_touch(s, w);
    end else if (taken) begin
      for (int i = 3; i >= 0; i--) if (!m_valid[s][i]) w = i;
      if (w < 0) w = m_victim(s);
      m_valid[s][w] = 1'b1;
      m_tag[s][w] = f_tag(pc);
      m_dest[s][w] = dest;
      m_conf[s][w] = 2;
      m_touch(s, w);
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 4; w++) begin m_valid[s][w] = 1'b0; m_conf[s][w] = 0; end
      for (int n = 0; n < 3; n++) m_node[s][n] = 0;
    end
    pend_v = 1'b0;
  endtask

  // Advance one clock edge, applying to the model what that edge does to the table.
  task automatic step();
    int w;
    if (flush) begin
      for (int s = 0; s < 16; s++) begin
        for (int i = 0; i < 4; i++) m_valid[s][i] = 1'b0;
        for (int n = 0; n < 3; n++) m_node[s][n] = 0;
      end
      pend_v = 1'b0;
    end else begin
      w = m_way(j_pc);
      if (w >= 0) m_touch(f_set(j_pc), w);
      if (pend_v) m_apply(pend_pc, pend_dest, pend_taken);
      pend_v = upd_valid;
      pend_pc = upd_pc;
      pend_dest = upd_dest;
      pend_taken = upd_taken;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [31:0] dest, input bit taken);
    upd_pc = pc; upd_dest = dest; upd_taken = taken; upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    step();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    upd_valid = 1'b0;
    flush = 1'b0;
    m_clear();
    #2;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [35:0] got;
    m_clear();
    #1 resetn = 1'b0;
    j_pc = 32'h8000_0100;
    #2;
    got = {hit, hit_pc, hit_pcp4, pred_taken, predict_pc};
    n_tests++;
    if (got !== 36'h0) begin n_fail++; $display("FAIL reset_in got=%h exp=0", got); end
    @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    got = {hit, hit_pc, hit_pcp4, pred_taken, predict_pc};
    n_tests++;
    if (got !== 36'h0) begin n_fail++; $display("FAIL reset_out got=%h exp=0", got); end
  endtask

  task automatic test_pcp4();
    logic [35:0] got;
    j_pc = 32'h8000_0100;
    upd_pc = 32'h8000_0104; upd_dest = 32'h8000_0400; upd_taken = 1'b1; upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    #1;
    got = {hit, hit_pc, hit_pcp4, pred_taken, predict_pc};
    n_tests++;
    if (got !== 36'h0) begin n_fail++; $display("FAIL pcp4_n1 got=%h exp=0", got); end
    step();
    #1;
    got = {hit, hit_pc, hit_pcp4, pred_taken, predict_pc};
    n_tests++;
    if (got !== {4'b1011, 32'h8000_0400}) begin
      n_fail++; $display("FAIL pcp4_n2 got=%h exp=%h", got, {4'b1011, 32'h8000_0400});
    end
  endtask

  task automatic test_plru();
    logic [31:0] pcs [5];
    logic [35:0] got, exp;
    do_reset();
    j_pc = PARK;
    for (int k = 0; k < 5; k++) pcs[k] = 32'h8000_0100 + 32'(k) * 32'h800;
    for (int k = 0; k < 4; k++) begin
      upd_pc = pcs[k]; upd_dest = 32'h9000_0000 + 32'(k) * 32'h10; upd_taken = 1'b1; upd_valid = 1'b1;
      step();
    end
    upd_valid = 1'b0;
    step();
    j_pc = pcs[0];
    #1;
    got = {hit, hit_pc, hit_pcp4, pred_taken, predict_pc};
    n_tests++;
    if (got !== {4'b1101, 32'h9000_0000}) begin n_fail++; $display("FAIL plru_hitA got=%h", got); end
    step();
    j_pc = PARK;
    do_upd(pcs[4], 32'h9000_0040, 1'b1);
    for (int k = 0; k < 5; k++) begin
      j_pc = pcs[k];
      #1;
      got = {hit, hit_pc, hit_pcp4, pred_taken, predict_pc};
      exp = (k == 2) ? 36'h0 : {4'b1101, 32'h9000_0000 + 32'(k) * 32'h10};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL plru_after_E way%0d got=%h exp=%h", k, got, exp); end
    end
    j_pc = PARK;
  endtask

  task automatic test_confidence();
    logic [31:0] p, d1;
    logic [35:0] got, exp;
    logic [31:0] dst [6];
    bit tk [6];
    bit pt [6];
    p = 32'h8000_0200;
    d1 = 32'h8000_0600;
    dst = '{d1, d1, d1, d1, d1, 32'h8000_0800};
    tk = '{1, 0, 0, 1, 1, 1};
    pt = '{1, 1, 0, 0, 1, 1};
    do_reset();
    j_pc = PARK;
    for (int k = 0; k < 6; k++) begin
      do_upd(p, dst[k], tk[k]);
      if (k == 1) continue;
      j_pc = p;
      #1;
      got = {hit, hit_pc, hit_pcp4, pred_taken, predict_pc};
      exp = {3'b110, pt[k], dst[k]};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL conf_step%0d got=%h exp=%h", k, got, exp); end
      j_pc = PARK;
    end
    do_upd(p, 32'h8000_0800, 1'b0);
    j_pc = p;
    #1;
    n_tests++;
    if (pred_taken !== 1'b0 || hit !== 1'b1) begin
      n_fail++; $display("FAIL conf_newdest_is2 got hit=%b taken=%b exp hit=1 taken=0", hit, pred_taken);
    end
    j_pc = PARK;
  endtask

  task automatic test_flush();
    logic [35:0] got;
    do_reset();
    j_pc = PARK;
    do_upd(32'h8000_0100, 32'h9000_0100, 1'b1);
    do_upd(32'h8000_0300, 32'h9000_0300, 1'b1);
    j_pc = 32'h8000_0100;
    #1;
    n_tests++;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL flush_pre got=%b exp=1", hit); end
    flush = 1'b1;
    upd_pc = 32'h8000_0500; upd_dest = 32'h9000_0500; upd_taken = 1'b1; upd_valid = 1'b1;
    step();
    flush = 1'b0;
    upd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      j_pc = (k == 0) ? 32'h8000_0100 : 32'h8000_0300;
      #1;
      got = {hit, hit_pc, hit_pcp4, pred_taken, predict_pc};
      n_tests++;
      if (got !== 36'h0) begin n_fail++; $display("FAIL flush_old%0d got=%h exp=0", k, got); end
    end
    j_pc = 32'h8000_0500;
    step();
    #1;
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL flush_drop_new got=%b exp=0", hit); end
    upd_pc = 32'h8000_0700; upd_dest = 32'h9000_0700; upd_taken = 1'b1; upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    j_pc = 32'h8000_0700;
    step();
    #1;
    n_tests++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL flush_drop_u2 got=%b exp=0", hit); end
    j_pc = PARK;
  endtask

  task automatic test_reset_mid();
    logic [35:0] got;
    do_reset();
    j_pc = PARK;
    do_upd(32'h8000_0900, 32'h9000_0900, 1'b1);
    j_pc = 32'h8000_0900;
    upd_pc = 32'h8000_1180; upd_dest = 32'h9000_1180; upd_taken = 1'b1; upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    resetn = 1'b0;
    m_clear();
    #1;
    got = {hit, hit_pc, hit_pcp4, pred_taken, predict_pc};
    n_tests++;
    if (got !== 36'h0) begin n_fail++; $display("FAIL rst_mid_out got=%h exp=0", got); end
    #1 resetn = 1'b1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      j_pc = (k == 0) ? 32'h8000_1180 : 32'h8000_0900;
      #1;
      n_tests++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_miss%0d got=%b exp=0", k, hit); end
    end
    j_pc = PARK;
  endtask

  task automatic test_back_to_back();
    logic [31:0] s, d1, d2;
    logic [35:0] got;
    bit tk [5];
    s = 32'h8000_0280; d1 = 32'h8000_1000; d2 = 32'h8000_2000;
    tk = '{1, 1, 0, 0, 1};
    do_reset();
    j_pc = PARK;
    for (int k = 0; k < 5; k++) begin
      upd_pc = s; upd_dest = (k == 0) ? d1 : d2; upd_taken = tk[k]; upd_valid = 1'b1;
      step();
    end
    upd_valid = 1'b0;
    step();
    j_pc = s;
    #1;
    got = {hit, hit_pc, hit_pcp4, pred_taken, predict_pc};
    n_tests++;
    if (got !== {4'b1100, d2}) begin n_fail++; $display("FAIL b2b_const got=%h exp=%h", got, {4'b1100, d2}); end
    n_tests++;
    if (got !== m_out(s)) begin n_fail++; $display("FAIL b2b_model got=%h exp=%h", got, m_out(s)); end
    j_pc = PARK;
  endtask

  function automatic logic [31:0] rnd_pc();
    return PARK | (32'($urandom_range(0, 5)) << 11) | (32'($urandom_range(0, 1)) << 7)
                | (32'($urandom_range(0, 1)) << 2);
  endfunction

  task automatic test_random();
    logic [35:0] got, exp;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      j_pc = rnd_pc();
      upd_valid = ($urandom_range(0, 2) != 0);
      upd_pc = rnd_pc();
      upd_dest = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) upd_dest = m_dest[f_set(upd_pc)][$urandom_range(0, 3)];
      upd_taken = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      #1;
      got = {hit, hit_pc, hit_pcp4, pred_taken, predict_pc};
      exp = m_out(j_pc);
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rand cycle %0d pc=%h got=%h exp=%h", i, j_pc, got, exp); end
      step();
    end
    flush = 1'b0;
    upd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pcp4();
    test_plru();
    test_confidence();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jht_nway.md
# jht_nway

N-way set-associative jump history table with per-entry 2-bit confidence and tree-PLRU replacement; generalised successor of the 2-way jump table. Sits beside the F1 fetch stage. A same-cycle lookup returns a predicted target for the fetch PC or PC+4. Resolved jumps and branches from EXE are registered and written one cycle later. A flush input invalidates every entry in one cycle.

## Interface
- ASSOCIATIVITY, 4: ways per set; power of 2, ≥2.
- SET_NUM, 16: sets; power of 2, ≥2.
- TAG_BITS, 18: tag = addr[2+TAG_BITS-1:2].
- INDEX_SHIFT, 7: index = addr[INDEX_SHIFT+INDEX_BITS-1:INDEX_SHIFT]; must be ≥3.
- clk  in  1  clock, all state on posedge.
- resetn  in  1  reset, asynchronous, active-low.
- j_pc  in  addr_t  fetch PC to predict (F1).
- predict_pc  out  addr_t  target of hitting entry, 0 when hit=0.
- hit  out  1  hit_pc | hit_pcp4.
- hit_pc  out  1  tag of j_pc found in set index(j_pc).
- hit_pcp4  out  1  tag of j_pc+4 found in set index(j_pc).
- pred_taken  out  1  hit & conf[1] of hitting entry.
- upd_valid  in  1  EXE reports resolved control-flow instr.
- upd_pc  in  addr_t  PC of resolved instr.
- upd_dest  in  addr_t  resolved target.
- upd_taken  in  1  resolved direction; 1 for j/jal.
- flush  in  1  invalidate all entries.

## Operation
- Storage: tag and dest arrays (no reset); valid, conf[1:0] and per-set PLRU (ASSOCIATIVITY-1 bits) in flops, cleared by resetn.
- Lookup (combinational, set index(j_pc)): hit_pc if any valid way tag == tag(j_pc); hit_pcp4 likewise for tag(j_pc+4); both use index(j_pc). Hit way: pc match wins over pc+4 match; within a match, highest way index wins.
- Update stage U1: at posedge with upd_valid=1, register {pc,dest,taken} into a 1-entry pending register (u_v=1); otherwise u_v←0.
- Update stage U2 (u_v=1), looks up set index(u_pc):
  - Hit, taken: dest←u_dest; conf sat-inc (max 3). If stored dest ≠ u_dest, conf←2 instead.
  - Hit, not taken: conf sat-dec (min 0); entry stays valid.
  - Miss, taken: allocate victim: lowest-index invalid way, else PLRU victim; write valid=1, tag, dest, conf=2.
  - Miss, not taken: no change.
- Tree-PLRU: node bit 0 = victim in lower half. Touching way w sets each node on its path to point away from w. Touch on predict hit (set index(j_pc), hit way) and on every U2 hit/allocate. Same set, same edge: apply predict touch first, then U2 touch (U2 wins on shared nodes).
- Flush at posedge: all valid←0, PLRU←0, u_v←0; upd_valid that edge is dropped. Tag/dest untouched.

## Timing
- Reset (async assert): valid, conf, PLRU, u_v = 0 immediately. Outputs then hit=hit_pc=hit_pcp4=pred_taken=0, predict_pc=0. Normal operation from first posedge after deassertion.
- Lookup latency 0: outputs combinational from j_pc and current state.
- Update latency: sampled at edge N, array written at edge N+1, visible to lookup in cycle after N+1. No forwarding from U1 to lookup.
- Back-to-back updates to same PC: each U2 sees the preceding U2's write; every update applied in order.
- Flush: lookups miss from the cycle after the flush edge. An update in U2 at the flush edge is discarded.
- Reset mid-update discards pending update; no partial write.

## Test plan
- Reset, j_pc=0x8000_0100 -> hit=0, predict_pc=0, pred_taken=0.
- upd 0x8000_0104→0x8000_0400 taken at edge N; j_pc=0x8000_0100: cycle N+1 miss; cycle N+2 hit_pcp4=1, hit_pc=0, predict_pc=0x8000_0400, pred_taken=1.
- Allocate A,B,C,D (taken, set 2, ways 0..3 in order); predict-hit A; allocate E -> E replaces way 2 (C); A, B, D still hit.
- Entry conf=2: two not-taken updates -> hit=1, pred_taken=0 (conf 0); taken -> still 0 (conf 1); taken -> pred_taken=1. Taken with new dest 0x8000_0800 -> predict_pc=0x8000_0800, conf=2.
- flush and upd_valid (new PC) at same edge -> next cycle every prior entry misses; two cycles later the new PC also misses.
- Assert resetn low between U1 and U2 of an update -> outputs 0 immediately; after release the PC misses.
